// File: rtl/bus_packet_dispatcher.sv
// Pops gbus packets, decodes them and presents them to the core-memory write fabric
// through a 2-entry output queue. Optional feature macro: BUS_PKT_DISPATCH_BCAST_EN.
module bus_packet_dispatcher #(
    parameter int BUS_DATA_WIDTH       = 32,
    parameter int HEAD_SRAM_BIAS_WIDTH = 2,
    parameter int BUS_CORE_ADDR_WIDTH  = 4,
    parameter int BUS_CMEM_ADDR_WIDTH  = 13,
    parameter int NUM_CORES            = 8,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [BUS_DATA_WIDTH+HEAD_SRAM_BIAS_WIDTH+BUS_CORE_ADDR_WIDTH+BUS_CMEM_ADDR_WIDTH-1:0] fifo_out_bus_packet,
    input  logic                                  fifo_buffer_empty,
    output logic                                  fifo_rd_en,
    output logic                                  pkt_valid,
    input  logic                                  pkt_ready,
    output logic [NUM_CORES-1:0]                  core_sel,
    output logic [BUS_CMEM_ADDR_WIDTH-1:0]        cmem_addr,
    output logic [HEAD_SRAM_BIAS_WIDTH-1:0]       sram_bias,
    output logic [BUS_DATA_WIDTH-1:0]             wr_data,
    output logic [CNT_WIDTH-1:0]                  pkt_cnt,
    output logic [CNT_WIDTH-1:0]                  drop_cnt,
    output logic                                  idle
);
    localparam int CORE_LSB = BUS_CMEM_ADDR_WIDTH;
    localparam int BIAS_LSB = CORE_LSB + BUS_CORE_ADDR_WIDTH;
    localparam int DATA_LSB = BIAS_LSB + HEAD_SRAM_BIAS_WIDTH;
    localparam logic [BUS_CORE_ADDR_WIDTH:0] CORE_LIMIT = (BUS_CORE_ADDR_WIDTH+1)'(NUM_CORES);

    typedef struct packed {
        logic [NUM_CORES-1:0]            core_sel;
        logic [BUS_CMEM_ADDR_WIDTH-1:0]  cmem_addr;
        logic [HEAD_SRAM_BIAS_WIDTH-1:0] sram_bias;
        logic [BUS_DATA_WIDTH-1:0]       wr_data;
    } entry_t;

    entry_t                         q_mem [2];
    entry_t                         head;
    entry_t                         in_entry;
    logic                           wr_ptr;
    logic                           rd_ptr;
    logic [1:0]                     q_cnt;
    logic                           inflight;
    logic [CNT_WIDTH-1:0]           pkt_cnt_q;
    logic [CNT_WIDTH-1:0]           drop_cnt_q;
    logic [CNT_WIDTH-1:0]           pkt_cnt_nxt;
    logic [CNT_WIDTH-1:0]           drop_cnt_nxt;
    logic [BUS_CORE_ADDR_WIDTH-1:0] in_core;
    logic                           in_range;
    logic                           push;
    logic                           drop;
    logic                           xfer;
    logic [2:0]                     slots_used;

    // Decode the word returned by the FIFO; only meaningful while a pop is in flight.
    always_comb begin
        in_core            = fifo_out_bus_packet[CORE_LSB +: BUS_CORE_ADDR_WIDTH];
        in_range           = ({1'b0, in_core} < CORE_LIMIT);
        in_entry.core_sel  = {{(NUM_CORES-1){1'b0}}, 1'b1} << in_core;
        in_entry.cmem_addr = fifo_out_bus_packet[0 +: BUS_CMEM_ADDR_WIDTH];
        in_entry.sram_bias = fifo_out_bus_packet[BIAS_LSB +: HEAD_SRAM_BIAS_WIDTH];
        in_entry.wr_data   = fifo_out_bus_packet[DATA_LSB +: BUS_DATA_WIDTH];
`ifdef BUS_PKT_DISPATCH_BCAST_EN
        if (in_core == '1) begin
            in_range          = 1'b1;
            in_entry.core_sel = '1;
        end
`else
`endif
    end

    assign xfer = pkt_valid & pkt_ready;
    assign push = inflight & in_range;
    assign drop = inflight & ~in_range;

    // A slot freed by this cycle's handshake can be reused by the pop issued now.
    assign slots_used = {1'b0, q_cnt} + {2'b00, inflight} - {2'b00, xfer};
    assign fifo_rd_en = ~fifo_buffer_empty & ~rst & (slots_used < 3'd2);

    assign pkt_cnt_nxt  = (xfer && pkt_cnt_q != '1) ? pkt_cnt_q + CNT_WIDTH'(1) : pkt_cnt_q;
    assign drop_cnt_nxt = (drop && drop_cnt_q != '1) ? drop_cnt_q + CNT_WIDTH'(1) : drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_mem[0]   <= '0;
            q_mem[1]   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            q_cnt      <= 2'd0;
            inflight   <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            inflight   <= fifo_rd_en;
            pkt_cnt_q  <= pkt_cnt_nxt;
            drop_cnt_q <= drop_cnt_nxt;
            if (push) begin
                q_mem[wr_ptr] <= in_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !xfer) begin
                q_cnt <= q_cnt + 2'd1;
            end else if (!push && xfer) begin
                q_cnt <= q_cnt - 2'd1;
            end
        end
    end

    assign head      = q_mem[rd_ptr];
    assign pkt_valid = (q_cnt != 2'd0);
    assign core_sel  = head.core_sel;
    assign cmem_addr = head.cmem_addr;
    assign sram_bias = head.sram_bias;
    assign wr_data   = head.wr_data;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign idle      = (q_cnt == 2'd0) & ~inflight & fifo_buffer_empty;

endmodule

// File: tb/tb_bus_packet_dispatcher.sv
// Randomised self-checking bench for bus_packet_dispatcher: emulates the registered-read
// FIFO and compares delivered packets against a queue-level model of the packet rules.
module tb_bus_packet_dispatcher;
    localparam int NUM_CORES_TB = 8;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [50:0] fifo_out_bus_packet;
    logic        fifo_buffer_empty;
    logic        fifo_rd_en;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  core_sel;
    logic [12:0] cmem_addr;
    logic [1:0]  sram_bias;
    logic [31:0] wr_data;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
    logic        idle;

    bus_packet_dispatcher dut (
        .clk                 (clk),
        .rst                 (rst),
        .fifo_out_bus_packet (fifo_out_bus_packet),
        .fifo_buffer_empty   (fifo_buffer_empty),
        .fifo_rd_en          (fifo_rd_en),
        .pkt_valid           (pkt_valid),
        .pkt_ready           (pkt_ready),
        .core_sel            (core_sel),
        .cmem_addr           (cmem_addr),
        .sram_bias           (sram_bias),
        .wr_data             (wr_data),
        .pkt_cnt             (pkt_cnt),
        .drop_cnt            (drop_cnt),
        .idle                (idle)
    );

    always #5 clk = ~clk;

    logic [50:0] pkt_mem [DEPTH];
    logic [54:0] exp_mem [DEPTH];
    logic [54:0] obs_mem [DEPTH];
    int          fifo_wr, fifo_rd, exp_n, obs_n, exp_drops;
    int          held, rd_violations, stall_violations;
    bit          pending_drop, was_stalled;
    logic [54:0] stall_head;
    int          checks, errors;

    function automatic logic [50:0] make_pkt(input logic [31:0] d, input logic [1:0] b,
                                             input logic [3:0] c, input logic [12:0] a);
        return {d, b, c, a};
    endfunction

    // Delivery rule straight from the packet definition: in-range cores (and optionally 4'hF) go out.
    function automatic bit model_deliver(input logic [50:0] p, output logic [7:0] sel);
        int core;
        core = int'(p[16:13]);
        sel  = 8'h00;
`ifdef BUS_PKT_DISPATCH_BCAST_EN
        if (core == 15) begin
            sel = 8'hFF;
            return 1'b1;
        end
`endif
        if (core < NUM_CORES_TB) begin
            sel = 8'(1 << core);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_pkt(input logic [50:0] p);
        logic [7:0] sel;
        pkt_mem[fifo_wr % DEPTH] = p;
        fifo_wr++;
        if (model_deliver(p, sel)) begin
            exp_mem[exp_n % DEPTH] = {sel, p[12:0], p[18:17], p[50:19]};
            exp_n++;
        end else begin
            exp_drops++;
        end
        fifo_buffer_empty = (fifo_rd == fifo_wr);
    endtask

    // One clock: sample at the falling edge, then model the FIFO's registered read after the rising edge.
    task automatic step_cycle(input bit ready);
        bit          s_rd, s_xfer;
        logic [54:0] cur;
        logic [7:0]  sel;
        pkt_ready = ready;
        @(negedge clk);
        s_rd   = fifo_rd_en;
        s_xfer = pkt_valid && pkt_ready;
        cur    = {core_sel, cmem_addr, sram_bias, wr_data};
        if (!rst) begin
            if (s_rd && fifo_buffer_empty) rd_violations++;
            if (s_rd && (held - int'(s_xfer)) >= 2) rd_violations++;
            if (was_stalled && (pkt_valid !== 1'b1 || cur !== stall_head)) stall_violations++;
            if (s_xfer) begin
                obs_mem[obs_n % DEPTH] = cur;
                obs_n++;
            end
        end
        was_stalled = pkt_valid && !pkt_ready && !rst;
        stall_head  = cur;
        @(posedge clk);
        #1;
        if (rst) begin
            held         = 0;
            pending_drop = 1'b0;
            was_stalled  = 1'b0;
            fifo_out_bus_packet = 51'({$urandom(), $urandom()});
        end else begin
            held = held + int'(s_rd) - int'(s_xfer) - int'(pending_drop);
            pending_drop = 1'b0;
            if (s_rd) begin
                fifo_out_bus_packet = pkt_mem[fifo_rd % DEPTH];
                pending_drop = !model_deliver(pkt_mem[fifo_rd % DEPTH], sel);
                fifo_rd++;
            end else begin
                fifo_out_bus_packet = 51'({$urandom(), $urandom()});
            end
            fifo_buffer_empty = (fifo_rd == fifo_wr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_rd = 0;
        fifo_wr = 0;
        fifo_buffer_empty = 1'b1;
        exp_n = 0;
        obs_n = 0;
        exp_drops = 0;
        step_cycle(1'b0);
        rst = 1'b0;
        rd_violations = 0;
        stall_violations = 0;
    endtask

    task automatic test_reset();
        step_cycle(1'b0);
        step_cycle(1'b0);
        checks++;
        if ({pkt_valid, core_sel, cmem_addr, sram_bias, wr_data, pkt_cnt, drop_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b sel=%h addr=%h bias=%h data=%h pc=%h dc=%h, required all 0",
                     pkt_valid, core_sel, cmem_addr, sram_bias, wr_data, pkt_cnt, drop_cnt);
        end
        checks++;
        if (idle !== 1'b1 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got idle=%b rd_en=%b, required idle=1 rd_en=0", idle, fifo_rd_en);
        end
    endtask

    task automatic test_single();
        do_reset();
        push_pkt(make_pkt(32'hDEADBEEF, 2'd2, 4'd3, 13'h0123));
        pkt_ready = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_rd_en_c0: got %b required 1", fifo_rd_en);
        end
        step_cycle(1'b1);
        checks++;
        if (pkt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_valid_c1: got %b required 0", pkt_valid);
        end
        step_cycle(1'b1);
        checks++;
        if (pkt_valid !== 1'b1 || core_sel !== 8'b0000_1000) begin
            errors++;
            $display("[TB] FAIL single_valid_c2: got valid=%b sel=%b required valid=1 sel=00001000", pkt_valid, core_sel);
        end
        checks++;
        if ({cmem_addr, sram_bias, wr_data} !== {13'h0123, 2'd2, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL single_fields: got addr=%h bias=%h data=%h required 0123/2/deadbeef", cmem_addr, sram_bias, wr_data);
        end
        step_cycle(1'b1);
        checks++;
        if (pkt_cnt !== 16'd1 || idle !== 1'b1 || obs_n != 1) begin
            errors++;
            $display("[TB] FAIL single_done: got pkt_cnt=%0d idle=%b delivered=%0d required 1/1/1", pkt_cnt, idle, obs_n);
        end
    endtask

    task automatic test_stream();
        int gaps;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            push_pkt(make_pkt(32'h1000 + 32'(i), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 13'($urandom())));
        end
        for (int w = 0; w < 6 && pkt_valid !== 1'b1; w++) step_cycle(1'b1);
        checks++;
        if (pkt_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_first_valid: got %b required 1", pkt_valid);
        end
        gaps = 0;
        for (int i = 0; i < 28; i++) begin
            if (pkt_valid !== 1'b1) gaps++;
            step_cycle(1'b1);
        end
        checks++;
        if (gaps != 0 || pkt_cnt !== 16'd28 || obs_n != 28) begin
            errors++;
            $display("[TB] FAIL stream_throughput: got gaps=%0d pkt_cnt=%0d delivered=%0d required 0/28/28", gaps, pkt_cnt, obs_n);
        end
        for (int i = 0; i < 28; i++) begin
            checks++;
            if (obs_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL stream_pkt%0d: got %h required %h", i, obs_mem[i], exp_mem[i]);
            end
        end
        checks++;
        if (rd_violations != 0) begin
            errors++;
            $display("[TB] FAIL stream_rd_rule: got %0d violations required 0", rd_violations);
        end
    endtask

    task automatic test_backpressure();
        bit rdy;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_pkt(make_pkt($urandom(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 13'($urandom())));
        end
        for (int cyc = 0; cyc < 300 && !(obs_n >= exp_n && idle === 1'b1); cyc++) begin
            rdy = (cyc < 4) ? (cyc == 0 || cyc == 3) : 1'($urandom_range(0, 1));
            step_cycle(rdy);
        end
        checks++;
        if (obs_n != 10 || pkt_cnt !== 16'd10) begin
            errors++;
            $display("[TB] FAIL bp_count: got delivered=%0d pkt_cnt=%0d required 10/10", obs_n, pkt_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL bp_pkt%0d: got %h required %h", i, obs_mem[i], exp_mem[i]);
            end
        end
        checks++;
        if (stall_violations != 0 || rd_violations != 0) begin
            errors++;
            $display("[TB] FAIL bp_rules: got stall=%0d rd=%0d violations required 0/0", stall_violations, rd_violations);
        end
    endtask

    task automatic test_drop();
        do_reset();
        push_pkt(make_pkt($urandom(), 2'd1, 4'd9, 13'h0001));
        push_pkt(make_pkt($urandom(), 2'd2, 4'd7, 13'h0002));
        push_pkt(make_pkt($urandom(), 2'd3, 4'd15, 13'h0003));
        for (int i = 0; i < 6; i++) begin
            push_pkt(make_pkt($urandom(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 13'($urandom())));
        end
        for (int cyc = 0; cyc < 100 && !(obs_n >= exp_n && idle === 1'b1); cyc++) step_cycle(1'b1);
        checks++;
        if (obs_mem[0][54:47] !== 8'b1000_0000) begin
            errors++;
            $display("[TB] FAIL drop_core7_sel: got %b required 10000000", obs_mem[0][54:47]);
        end
`ifdef BUS_PKT_DISPATCH_BCAST_EN
        checks++;
        if (obs_mem[1][54:47] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL drop_bcast_sel: got %h required ff", obs_mem[1][54:47]);
        end
`endif
        checks++;
        if (drop_cnt !== 16'(exp_drops) || pkt_cnt !== 16'(exp_n) || obs_n != exp_n) begin
            errors++;
            $display("[TB] FAIL drop_counts: got drop=%0d pkt=%0d delivered=%0d required %0d/%0d/%0d",
                     drop_cnt, pkt_cnt, obs_n, exp_drops, exp_n, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (obs_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL drop_pkt%0d: got %h required %h", i, obs_mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_pkt(make_pkt($urandom(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 13'($urandom())));
        end
        for (int i = 0; i < 4; i++) step_cycle(1'b0);
        step_cycle(1'b1);
        checks++;
        if (pkt_cnt !== 16'd1 || pkt_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre: got pkt_cnt=%0d valid=%b required 1/1", pkt_cnt, pkt_valid);
        end
        pkt_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_rd_en: got %b required 0", fifo_rd_en);
        end
        fifo_rd = fifo_wr;
        fifo_buffer_empty = 1'b1;
        step_cycle(1'b0);
        checks++;
        if ({pkt_valid, core_sel, cmem_addr, sram_bias, wr_data, pkt_cnt, drop_cnt} !== '0 || idle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got valid=%b sel=%h data=%h pc=%0d dc=%0d idle=%b required zeros, idle=1",
                     pkt_valid, core_sel, wr_data, pkt_cnt, drop_cnt, idle);
        end
        rst = 1'b0;
        exp_n = 0;
        obs_n = 0;
        exp_drops = 0;
        push_pkt(make_pkt($urandom(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 13'($urandom())));
        for (int cyc = 0; cyc < 10 && obs_n < 1; cyc++) step_cycle(1'b1);
        checks++;
        if (obs_n != 1 || obs_mem[0] !== exp_mem[0] || pkt_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midrst_after: got delivered=%0d pkt=%h pkt_cnt=%0d required 1/%h/1", obs_n, obs_mem[0], pkt_cnt, exp_mem[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.pkt_cnt_q = 16'hFFFE;
        step_cycle(1'b0);
        release dut.pkt_cnt_q;
        #1;
        checks++;
        if (pkt_cnt !== 16'hFFFE) begin
            errors++;
            $display("[TB] FAIL sat_preload: got %h required fffe", pkt_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            push_pkt(make_pkt($urandom(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 13'($urandom())));
        end
        for (int cyc = 0; cyc < 20 && obs_n < 3; cyc++) step_cycle(1'b1);
        checks++;
        if (pkt_cnt !== 16'hFFFF || obs_n != 3) begin
            errors++;
            $display("[TB] FAIL sat_hold: got pkt_cnt=%h delivered=%0d required ffff/3", pkt_cnt, obs_n);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        pkt_ready = 1'b0;
        fifo_buffer_empty = 1'b1;
        fifo_out_bus_packet = '0;
        fifo_wr = 0;
        fifo_rd = 0;
        exp_n = 0;
        obs_n = 0;
        exp_drops = 0;
        held = 0;
        rd_violations = 0;
        stall_violations = 0;
        pending_drop = 1'b0;
        was_stalled = 1'b0;
        stall_head = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_drop();
        test_reset_midstream();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] time limit");
    end

endmodule
